// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//
// Sequencer for a multiply-accumulate datapath. A frame is one accumulator
// clear, a run of MAC issue cycles (operand loads), a drain period that lets
// the multiplier pipeline empty into the accumulator, and a single result
// register load. The controller then reports done and waits for an
// acknowledge. In continuous mode it immediately starts another frame of
// the same length after the acknowledge.
//
// Parameters
//   CNT_W    width of the frame length and of the issue counter
//   PIPE_LAT multiplier latency in cycles (0..7); sets the acc_en delay and
//            the drain length
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset (highest priority)
//   go       start request, only looked at while idle
//   stop     early-terminate request, only looked at while running
//   abort    drop the current frame and return to idle, any state
//   len      MAC cycles per frame, captured when a start is accepted
//   cont     continuous mode, captured when a start is accepted
//   ack      acknowledge of done, only looked at in done
//   ld_a     operand A register load enable
//   ld_b     operand B register load enable
//   acc_clr  accumulator clear
//   acc_en   accumulate enable, ld_a delayed to line up with the multiplier
//   ld_out   result register load
//   idle     controller waiting for a start
//   busy     frame in progress
//   done     frame finished, waiting for ack
//   cnt      MAC cycles issued in the current / most recent frame
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             stop,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  input  logic             cont,
  input  logic             ack,
  output logic             ld_a,
  output logic             ld_b,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             ld_out,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Index of the final drain cycle. Unused when there is no pipeline
  // latency, since the drain state is then never entered.
  localparam logic [2:0] DRAIN_LAST = (PIPE_LAT == 0) ? 3'd0 : 3'(PIPE_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] len_q;
  logic             cont_q;
  logic [2:0]       drain_cnt;
  logic             run_last;

  // cnt still holds the count before the current RUN cycle, so the frame
  // ends on the cycle where one more issue reaches the latched length.
  assign run_last = stop || ((cnt + CNT_W'(1)) == len_q);

  // Next-state decode. Abort overrides everything else (including a start
  // request seen in the same cycle); unused encodings fall back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go && (len != '0)) begin
          state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (run_last) begin
          state_nxt = (PIPE_LAT == 0) ? S_STORE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = S_STORE;
        end
      end
      S_STORE: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ack) begin
          state_nxt = cont_q ? S_CLR : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // State register plus all registered outputs. The strobes and status
  // flags are decoded from the next state so they are glitch-free flops
  // that are valid for the whole cycle spent in the matching state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      cont_q    <= 1'b0;
      drain_cnt <= '0;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      acc_clr   <= 1'b0;
      ld_out    <= 1'b0;
      idle      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      ld_a    <= (state_nxt == S_RUN);
      ld_b    <= (state_nxt == S_RUN);
      acc_clr <= (state_nxt == S_CLR);
      ld_out  <= (state_nxt == S_STORE);
      idle    <= (state_nxt == S_IDLE);
      busy    <= (state_nxt == S_CLR) || (state_nxt == S_RUN) ||
                 (state_nxt == S_DRAIN) || (state_nxt == S_STORE);
      done    <= (state_nxt == S_DONE);

      // Frame parameters are only captured on a fresh start; continuous
      // restarts from DONE reuse the previous values.
      if ((state == S_IDLE) && (state_nxt == S_CLR)) begin
        len_q  <= len;
        cont_q <= cont;
      end

      // The counter clears on entry to CLR and otherwise only moves in RUN,
      // so it keeps the final issue count until the next frame begins.
      if (state_nxt == S_CLR) begin
        cnt <= '0;
      end else if (state == S_RUN) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state != S_DRAIN) begin
        drain_cnt <= '0;
      end else begin
        drain_cnt <= drain_cnt + 3'd1;
      end
    end
  end

  // Accumulate enable: ld_a delayed by the multiplier latency so the
  // accumulator only adds products of issued operands. Abort and reset
  // empty the delay line so no stale product lands in the accumulator.
  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign acc_en = ld_a;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] acc_sr;

      always_ff @(posedge clk) begin
        if (rst || abort) begin
          acc_sr <= '0;
        end else begin
          acc_sr[0] <= ld_a;
          for (int i = 1; i < PIPE_LAT; i++) begin
            acc_sr[i] <= acc_sr[i-1];
          end
        end
      end

      assign acc_en = acc_sr[PIPE_LAT-1];
    end
  endgenerate

endmodule
